// File: rtl/fft4_pkg.sv
// Shared constants, state encoding and power-width helper for the 4-bin
// spectral power accumulator.
package fft4_pkg;

    localparam int NBINS    = 4;
    localparam int SAMPLE_W = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    function automatic int pow_w();
        return 6;
    endfunction

endpackage

// File: rtl/fft4_bin_power.sv
// Combinational |X|^2 = re^2 + im^2 for one FFT bin; the real part may be
// treated as unsigned (DC bin) or signed.
module fft4_bin_power
    import fft4_pkg::*;
(
    input  logic [SAMPLE_W-1:0] re,
    input  logic [SAMPLE_W-1:0] im,
    input  logic                is_unsigned_re,
    output logic [pow_w()-1:0]  p
);

    localparam int PW = pow_w();
    localparam int EW = SAMPLE_W + 1;
    localparam int SW = 2 * EW;
    localparam logic [SW-1:0] PMAX = SW'((1 << PW) - 1);

    logic [EW-1:0]        re_ext;
    logic [EW-1:0]        im_ext;
    logic signed [SW-1:0] re_w;
    logic signed [SW-1:0] im_w;
    logic [SW-1:0]        sum;

    always_comb begin
        re_ext = is_unsigned_re ? {1'b0, re} : {re[SAMPLE_W-1], re};
        im_ext = {im[SAMPLE_W-1], im};
        re_w   = {{(SW - EW){re_ext[EW-1]}}, re_ext};
        im_w   = {{(SW - EW){im_ext[EW-1]}}, im_ext};
        sum    = re_w * re_w + im_w * im_w;
        // An out-of-range unsigned DC sample clamps rather than wrapping.
        p      = (sum > PMAX) ? '1 : sum[PW-1:0];
    end

endmodule

// File: rtl/fft4_power_acc.sv
// Integrates per-bin power over FRAMES spectrum frames, then streams the four
// saturated totals out over valid/ready and clears for the next window.
module fft4_power_acc
    import fft4_pkg::*;
#(
    parameter int FRAMES = 16,
    parameter int ACC_W  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] rout_0,
    input  logic [SAMPLE_W-1:0] rout_1,
    input  logic [SAMPLE_W-1:0] rout_2,
    input  logic [SAMPLE_W-1:0] rout_3,
    input  logic [SAMPLE_W-1:0] iout_0,
    input  logic [SAMPLE_W-1:0] iout_1,
    input  logic [SAMPLE_W-1:0] iout_2,
    input  logic [SAMPLE_W-1:0] iout_3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_bin,
    output logic [ACC_W-1:0]    out_power,
    output logic                out_last
);

    localparam int PW    = pow_w();
    localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES - 1);

    logic [SAMPLE_W-1:0] re_vec  [NBINS];
    logic [SAMPLE_W-1:0] im_vec  [NBINS];
    logic [PW-1:0]       p_vec   [NBINS];
    logic [ACC_W:0]      acc_sum [NBINS];
    logic [ACC_W-1:0]    acc_sat [NBINS];
    logic [ACC_W-1:0]    acc_reg [NBINS];

    state_t           state_reg;
    logic             init_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [1:0]       idx_reg;
    logic             out_valid_reg;
    logic [ACC_W-1:0] out_power_reg;
    logic             out_last_reg;
    logic             accept;

    assign re_vec[0] = rout_0;
    assign re_vec[1] = rout_1;
    assign re_vec[2] = rout_2;
    assign re_vec[3] = rout_3;
    assign im_vec[0] = iout_0;
    assign im_vec[1] = iout_1;
    assign im_vec[2] = iout_2;
    assign im_vec[3] = iout_3;

    genvar gi;
    generate
        for (gi = 0; gi < NBINS; gi++) begin : g_bin
            // Bin 0 is the DC term and arrives unsigned from the FFT stage.
            fft4_bin_power u_power (
                .re             (re_vec[gi]),
                .im             (im_vec[gi]),
                .is_unsigned_re (gi == 0),
                .p              (p_vec[gi])
            );
            assign acc_sum[gi] = {1'b0, acc_reg[gi]} + (ACC_W + 1)'(p_vec[gi]);
            assign acc_sat[gi] = acc_sum[gi][ACC_W] ? {ACC_W{1'b1}} : acc_sum[gi][ACC_W-1:0];
        end
    endgenerate

    // init_reg holds off in_ready until the first edge after reset release.
    assign in_ready  = (state_reg == ACCUM) && init_reg;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_bin   = idx_reg;
    assign out_power = out_power_reg;
    assign out_last  = out_last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACCUM;
            init_reg      <= 1'b0;
            frame_cnt_reg <= '0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_power_reg <= '0;
            out_last_reg  <= 1'b0;
            for (int k = 0; k < NBINS; k++) acc_reg[k] <= '0;
        end else begin
            init_reg <= 1'b1;
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        for (int k = 0; k < NBINS; k++) acc_reg[k] <= acc_sat[k];
                        if (frame_cnt_reg == LAST_CNT) begin
                            frame_cnt_reg <= '0;
                            idx_reg       <= '0;
                            state_reg     <= DUMP;
                            out_valid_reg <= 1'b1;
                            out_power_reg <= acc_sat[0];
                            out_last_reg  <= 1'b0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        if (idx_reg == 2'd3) begin
                            for (int k = 0; k < NBINS; k++) acc_reg[k] <= '0;
                            state_reg     <= ACCUM;
                            idx_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            out_power_reg <= '0;
                            out_last_reg  <= 1'b0;
                        end else begin
                            idx_reg       <= idx_reg + 2'd1;
                            out_power_reg <= acc_reg[idx_reg + 2'd1];
                            out_last_reg  <= (idx_reg == 2'd2);
                        end
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fft4_power_acc.sv
// Scoreboard bench for fft4_power_acc: three instances cover the default,
// narrow-accumulator and single-frame configurations.
module tb_fft4_power_acc;

    typedef struct {
        int dut;
        int bin;
        int power;
        int last;
        int cyc;
    } beat_t;

    typedef struct {
        int dut;
        int cyc;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       out_last  [3];
    logic [1:0] out_bin   [3];
    logic [2:0] rr [3][4];
    logic [2:0] ii [3][4];
    logic [8:0] pw0;
    logic [7:0] pw1;
    logic [8:0] pw2;

    int    cyc = 0;
    int    total = 0;
    int    passed = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    acc_t  acc_q[$];
    int    cur_re [3][4];
    int    cur_im [3][4];
    int    m_acc  [3][4];
    int    m_cnt  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft4_power_acc #(.FRAMES(16), .ACC_W(9)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .rout_0(rr[0][0]), .rout_1(rr[0][1]), .rout_2(rr[0][2]), .rout_3(rr[0][3]),
        .iout_0(ii[0][0]), .iout_1(ii[0][1]), .iout_2(ii[0][2]), .iout_3(ii[0][3]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bin(out_bin[0]),
        .out_power(pw0), .out_last(out_last[0])
    );

    fft4_power_acc #(.FRAMES(16), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .rout_0(rr[1][0]), .rout_1(rr[1][1]), .rout_2(rr[1][2]), .rout_3(rr[1][3]),
        .iout_0(ii[1][0]), .iout_1(ii[1][1]), .iout_2(ii[1][2]), .iout_3(ii[1][3]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bin(out_bin[1]),
        .out_power(pw1), .out_last(out_last[1])
    );

    fft4_power_acc #(.FRAMES(1), .ACC_W(9)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .rout_0(rr[2][0]), .rout_1(rr[2][1]), .rout_2(rr[2][2]), .rout_3(rr[2][3]),
        .iout_0(ii[2][0]), .iout_1(ii[2][1]), .iout_2(ii[2][2]), .iout_3(ii[2][3]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_bin(out_bin[2]),
        .out_power(pw2), .out_last(out_last[2])
    );

    function automatic int pow_of(input int d);
        case (d)
            0:       return int'(pw0);
            1:       return int'(pw1);
            default: return int'(pw2);
        endcase
    endfunction

    function automatic int frames_of(input int d);
        return (d == 2) ? 1 : 16;
    endfunction

    function automatic int accmax_of(input int d);
        return (d == 1) ? 255 : 511;
    endfunction

    // Output and input handshakes are logged away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (out_valid[d] && out_ready[d])
                got_q.push_back('{d, int'(out_bin[d]), pow_of(d), int'(out_last[d]), cyc});
            if (in_valid[d] && in_ready[d])
                acc_q.push_back('{d, cyc});
        end
    end

    task automatic set_frame(input int d, input int r0, input int r1, input int r2, input int r3,
                             input int i0, input int i1, input int i2, input int i3);
        cur_re[d][0] = r0; cur_re[d][1] = r1; cur_re[d][2] = r2; cur_re[d][3] = r3;
        cur_im[d][0] = i0; cur_im[d][1] = i1; cur_im[d][2] = i2; cur_im[d][3] = i3;
        for (int k = 0; k < 4; k++) begin
            rr[d][k] = 3'(cur_re[d][k]);
            ii[d][k] = 3'(cur_im[d][k]);
        end
    endtask

    task automatic model_add(input int d);
        int p;
        for (int k = 0; k < 4; k++) begin
            p = cur_re[d][k] * cur_re[d][k] + cur_im[d][k] * cur_im[d][k];
            m_acc[d][k] = m_acc[d][k] + p;
            if (m_acc[d][k] > accmax_of(d)) m_acc[d][k] = accmax_of(d);
        end
        m_cnt[d]++;
        if (m_cnt[d] == frames_of(d)) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{d, k, m_acc[d][k], (k == 3) ? 1 : 0, 0});
                m_acc[d][k] = 0;
            end
            m_cnt[d] = 0;
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0;
            for (int k = 0; k < 4; k++) m_acc[d][k] = 0;
        end
    endtask

    // Offers the current frame until n frames are accepted; called and returns at posedge+1.
    task automatic send_frames(input int d, input int n, input bit keep);
        int done = 0;
        int guard = 0;
        in_valid[d] = 1'b1;
        while (done < n && guard < 300) begin
            @(negedge clk);
            guard++;
            if (in_ready[d]) begin
                done++;
                model_add(d);
            end
            @(posedge clk);
            #1;
        end
        if (!keep) in_valid[d] = 1'b0;
        total++;
        if (done !== n) $display("FAIL send_frames dut%0d: accepted %0d, required %0d", d, done, n);
        else passed++;
    endtask

    task automatic wait_beats(input int n);
        int guard = 0;
        while (got_q.size() < n && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_bin[0] !== 2'd0 ||
            pw0 !== 9'd0 || out_last[0] !== 1'b0) begin
            $display("FAIL reset_outputs: rdy=%b vld=%b bin=%0d pwr=%0d last=%b, required all 0",
                     in_ready[0], out_valid[0], out_bin[0], pw0, out_last[0]);
        end else passed++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (in_ready[0] !== 1'b0) $display("FAIL reset_release_ready: got %b, required 0", in_ready[0]);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (in_ready[0] !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", in_ready[0]);
        else passed++;
        $display("reset done");
    endtask

    task automatic test_dc();
        int last_acc;
        beat_t g;
        beat_t e;
        out_ready[0] = 1'b1;
        set_frame(0, 4, 0, 0, 0, 0, 0, 0, 0);
        send_frames(0, 16, 0);
        last_acc = (acc_q.size() > 0) ? acc_q[$].cyc : -100;
        wait_beats(4);
        total++;
        if (got_q.size() < 4) begin
            $display("FAIL dc_timing: %0d beats seen, required 4", got_q.size());
        end else if (got_q[0].cyc - last_acc !== 1 || got_q[3].cyc - got_q[0].cyc !== 3) begin
            $display("FAIL dc_timing: first beat +%0d, span %0d; required +1, span 3",
                     got_q[0].cyc - last_acc, got_q[3].cyc - got_q[0].cyc);
        end else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL dc_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("dc beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL dc_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_alternating();
        beat_t g;
        beat_t e;
        out_ready[0] = 1'b1;
        for (int f = 0; f < 8; f++) begin
            set_frame(0, 1, 1, 1, 1, 0, 0, 0, 0);
            send_frames(0, 1, 0);
            set_frame(0, 1, 0, -1, 0, 0, -1, 0, 1);
            send_frames(0, 1, 0);
        end
        wait_beats(4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL alt_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("alt beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL alt_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_saturation();
        beat_t g;
        beat_t e;
        out_ready[1] = 1'b1;
        set_frame(1, 4, 0, 0, 0, 0, -4, 0, 0);
        send_frames(1, 16, 0);
        wait_beats(4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL sat_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("sat beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL sat_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
        out_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int    n_acc;
        int    last_beat_cyc;
        logic  sv;
        logic  sl;
        logic [1:0] sb;
        logic [8:0] sp;
        bit    stable;
        beat_t g;
        beat_t e;
        out_ready[0] = 1'b0;
        set_frame(0, 5, 2, 0, -3, 1, 0, 1, -1);
        send_frames(0, 16, 1);
        n_acc = acc_q.size();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            sv = out_valid[0]; sb = out_bin[0]; sp = pw0; sl = out_last[0];
            stable = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (out_valid[0] !== sv || out_bin[0] !== sb || pw0 !== sp || out_last[0] !== sl)
                    stable = 1'b0;
            end
            total++;
            if (!stable || sv !== 1'b1)
                $display("FAIL hold_beat%0d: stable=%0d valid=%b, required stable=1 valid=1", b, stable, sv);
            else passed++;
            @(posedge clk);
            #1 out_ready[0] = 1'b1;
            @(posedge clk);
            #1 out_ready[0] = 1'b0;
        end
        last_beat_cyc = (got_q.size() > 0) ? got_q[$].cyc : -100;
        total++;
        if (acc_q.size() !== n_acc || in_ready[0] !== 1'b1)
            $display("FAIL dump_stall: accepts %0d rdy=%b, required accepts %0d rdy=1",
                     acc_q.size(), in_ready[0], n_acc);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (acc_q.size() !== n_acc + 1 || acc_q[$].cyc - last_beat_cyc !== 1)
            $display("FAIL resume_accept: accepts %0d, required %0d one cycle after bin 3",
                     acc_q.size(), n_acc + 1);
        else passed++;
        in_valid[0] = 1'b0;
        model_add(0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL bp_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("bp beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL bp_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_dump();
        beat_t g;
        beat_t e;
        out_ready[0] = 1'b0;
        set_frame(0, 3, 0, 0, 0, 0, 0, 0, 0);
        send_frames(0, 16 - m_cnt[0], 0);
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid[0] !== 1'b1 || out_bin[0] !== 2'd2)
            $display("FAIL pre_reset_bin: valid=%b bin=%0d, required valid=1 bin=2", out_valid[0], out_bin[0]);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || out_bin[0] !== 2'd0 || pw0 !== 9'd0 ||
            out_last[0] !== 1'b0 || in_ready[0] !== 1'b0)
            $display("FAIL async_reset: vld=%b bin=%0d pwr=%0d last=%b rdy=%b, required all 0",
                     out_valid[0], out_bin[0], pw0, out_last[0], in_ready[0]);
        else passed++;
        got_q.delete();
        exp_q.delete();
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready[0] = 1'b1;
        set_frame(0, 1, 0, 0, 0, 0, 0, 0, 0);
        send_frames(0, 16, 0);
        wait_beats(4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL rst_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("rst beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL rst_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_single_frame();
        int period;
        beat_t g;
        beat_t e;
        out_ready[2] = 1'b1;
        set_frame(2, 0, 0, -2, 0, 0, 0, 2, 0);
        send_frames(2, 2, 1);
        in_valid[2] = 1'b0;
        wait_beats(8);
        period = (acc_q.size() >= 2) ? acc_q[$].cyc - acc_q[$-1].cyc : -1;
        total++;
        if (period !== 5) $display("FAIL frames1_period: got %0d cycles, required 5", period);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL f1_beat%0d: got %0d queued, required %0d", i, got_q.size(), exp_q.size());
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("f1 beat dut=%0d bin=%0d power=%0d last=%0d", g.dut, g.bin, g.power, g.last);
            if (g.dut !== e.dut || g.bin !== e.bin || g.power !== e.power || g.last !== e.last)
                $display("FAIL f1_beat%0d: got bin=%0d pwr=%0d last=%0d, required bin=%0d pwr=%0d last=%0d",
                         i, g.bin, g.power, g.last, e.bin, e.power, e.last);
            else passed++;
        end
        out_ready[2] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            set_frame(d, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        model_clear();
        test_reset();
        test_dc();
        test_alternating();
        test_saturation();
        test_back_to_back();
        test_reset_mid_dump();
        test_single_frame();
        total++;
        if (got_q.size() !== 0 || exp_q.size() !== 0)
            $display("FAIL leftover_beats: got %0d, expected %0d, required 0 and 0", got_q.size(), exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
